// File: rtl/if_stage_if.sv
// if_stage_if: bundles the fetch stage's ID-side control and instruction-memory signals.
//
// Signals:
//   IFWrite        ID hazard enable; 0 freezes PC and IF/ID
//   Branch, Jump   ID redirect requests (branch taken, JAL/JALR)
//   JumpAddr       redirect target
//   imem_req       fetch request (driven by the fetch stage)
//   imem_addr      fetch address, always the current PC
//   imem_valid     one-cycle response strobe for the outstanding request
//   imem_rdata     instruction word, valid with imem_valid
//   Instruction_id IF/ID instruction register
//   PC_id          IF/ID PC register
//   fetch_wait_cnt, flush_cnt   optional counters, present only with IF_PERF_CNT_EN
//
// Modports: master = fetch stage, slave = decode stage / instruction memory side.
// Optional feature macro: IF_PERF_CNT_EN.

interface if_stage_if;
  logic        IFWrite;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_id;
  logic [31:0] PC_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_wait_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    input  IFWrite,
    input  Branch,
    input  Jump,
    input  JumpAddr,
    input  imem_valid,
    input  imem_rdata,
    output imem_req,
    output imem_addr,
    output Instruction_id,
`ifdef IF_PERF_CNT_EN
    output fetch_wait_cnt,
    output flush_cnt,
`endif
    output PC_id
  );

  modport slave (
    output IFWrite,
    output Branch,
    output Jump,
    output JumpAddr,
    output imem_valid,
    output imem_rdata,
    input  imem_req,
    input  imem_addr,
    input  Instruction_id,
`ifdef IF_PERF_CNT_EN
    input  fetch_wait_cnt,
    input  flush_cnt,
`endif
    input  PC_id
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a single-outstanding-request memory port and an
// IF/ID pipeline register.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    if_stage_if.master (ID control, instruction memory port, IF/ID outputs)
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  bubble written into IF/ID
//
// Fetch FSM:
//   StReq   request outstanding at the current PC (imem_req=1)
//   StHold  word captured while ID is stalled (imem_req=0)
//   StDrop  redirect arrived before the response; the stale word is discarded (imem_req=0)
//
// Optional feature macro: IF_PERF_CNT_EN adds fetch_wait_cnt (StReq cycles without a
// response) and flush_cnt (redirect cycles). Both wrap and reset to 0.

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic         clk,
  input logic         reset,
  if_stage_if.master  bus
);

  typedef enum logic [1:0] {StReq, StHold, StDrop} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] instr_id_q;
  logic [31:0] pc_id_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc_q;

  logic        redirect;
  logic [31:0] pc_inc;

  // A stalled ID stage cannot commit to a branch, so redirects are gated by IFWrite.
  always_comb begin
    redirect = (bus.Branch | bus.Jump) & bus.IFWrite;
    pc_inc   = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StReq;
      req_q        <= 1'b1;
      pc_q         <= RESET_PC;
      instr_id_q   <= NOP_INSTR;
      pc_id_q      <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
    end else begin
      case (state_q)
        StReq: begin
          if (redirect) begin
            pc_q       <= bus.JumpAddr;
            instr_id_q <= NOP_INSTR;
            if (bus.imem_valid) begin
              // Response and redirect coincide: drop the word, request the target next.
              state_q <= StReq;
              req_q   <= 1'b1;
            end else begin
              // Response still in flight; it must be swallowed before refetching.
              state_q <= StDrop;
              req_q   <= 1'b0;
            end
          end else if (bus.imem_valid) begin
            if (bus.IFWrite) begin
              instr_id_q <= bus.imem_rdata;
              pc_id_q    <= pc_q;
              pc_q       <= pc_inc;
            end else begin
              hold_instr_q <= bus.imem_rdata;
              hold_pc_q    <= pc_q;
              state_q      <= StHold;
              req_q        <= 1'b0;
            end
          end else if (bus.IFWrite) begin
            // Nothing fetched yet: ID advances on a bubble, PC_id keeps its value.
            instr_id_q <= NOP_INSTR;
          end
        end

        StHold: begin
          if (redirect) begin
            pc_q         <= bus.JumpAddr;
            instr_id_q   <= NOP_INSTR;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
            state_q      <= StReq;
            req_q        <= 1'b1;
          end else if (bus.IFWrite) begin
            instr_id_q <= hold_instr_q;
            pc_id_q    <= hold_pc_q;
            pc_q       <= pc_inc;
            state_q    <= StReq;
            req_q      <= 1'b1;
          end
        end

        StDrop: begin
          if (redirect) begin
            pc_q       <= bus.JumpAddr;
            instr_id_q <= NOP_INSTR;
          end else if (bus.IFWrite) begin
            instr_id_q <= NOP_INSTR;
          end
          if (bus.imem_valid) begin
            state_q <= StReq;
            req_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req       = req_q;
  assign bus.imem_addr      = pc_q;
  assign bus.Instruction_id = instr_id_q;
  assign bus.PC_id          = pc_id_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_wait_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_wait_cnt_q <= 32'h0;
      flush_cnt_q      <= 32'h0;
    end else begin
      if ((state_q == StReq) && !bus.imem_valid) begin
        fetch_wait_cnt_q <= fetch_wait_cnt_q + 32'd1;
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bus.fetch_wait_cnt = fetch_wait_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Instruction memory model
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          fix_lat;
  logic        rand_lat;

  // Reference model: architectural view of fetch
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic        m_stale;     // an in-flight response belongs to a discarded path
  logic [63:0] held[$];     // fetched word waiting for ID to unstall
  logic [31:0] m_wait;
  logic [31:0] m_flush;

  function automatic logic [31:0] w(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_instr  = NOP;
    m_pcid   = 32'h0;
    m_stale  = 1'b0;
    held.delete();
    m_wait   = 32'h0;
    m_flush  = 32'h0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr = 32'h0;
  endtask

  task automatic do_reset();
    bus.imem_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_instr", bus.Instruction_id, NOP);
    chk("rst_pcid", bus.PC_id, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_wait_cnt", bus.fetch_wait_cnt, 32'h0);
    chk("rst_flush_cnt", bus.flush_cnt, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic ifw, input logic br, input logic jp, input logic [31:0] ja);
    logic        v;
    logic [31:0] rd;
    logic        redir;
    logic        mreq;
    logic [63:0] h;
    v  = mem_busy && (mem_cnt == 0);
    rd = v ? w(mem_addr) : $urandom;
    bus.IFWrite    = ifw;
    bus.Branch     = br;
    bus.Jump       = jp;
    bus.JumpAddr   = ja;
    bus.imem_valid = v;
    bus.imem_rdata = rd;

    mreq = !m_stale && (held.size() == 0);
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, mreq});
    chk("imem_addr", bus.imem_addr, m_pc);
    if (bus.imem_req && mem_busy) chk("addr_stable", bus.imem_addr, mem_addr);
`ifdef IF_PERF_CNT_EN
    chk("fetch_wait_cnt", bus.fetch_wait_cnt, m_wait);
    chk("flush_cnt", bus.flush_cnt, m_flush);
`endif

    redir = (br | jp) & ifw;
    if (mreq && !v) m_wait++;
    if (redir) m_flush++;
    if (redir) begin
      m_pc    = ja;
      m_instr = NOP;
      held.delete();
      if (mreq && !v) m_stale = 1'b1;
      else if (v)     m_stale = 1'b0;
    end else if (m_stale) begin
      if (v) m_stale = 1'b0;
      if (ifw) m_instr = NOP;
    end else if (held.size() != 0) begin
      if (ifw) begin
        h       = held.pop_front();
        m_instr = h[63:32];
        m_pcid  = h[31:0];
        m_pc    = m_pc + 32'd4;
      end
    end else if (v) begin
      if (ifw) begin
        m_instr = rd;
        m_pcid  = m_pc;
        m_pc    = m_pc + 32'd4;
      end else begin
        held.push_back({rd, m_pc});
      end
    end else if (ifw) begin
      m_instr = NOP;
    end

    if (v) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    else if (bus.imem_req) begin
      mem_busy = 1'b1;
      mem_addr = bus.imem_addr;
      mem_cnt  = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
    end

    @(posedge clk);
    @(negedge clk);
    chk("Instruction_id", bus.Instruction_id, m_instr);
    chk("PC_id", bus.PC_id, m_pcid);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    fix_lat  = 0;
    rand_lat = 1'b0;
    bus.IFWrite    = 1'b1;
    bus.Branch     = 1'b0;
    bus.Jump       = 1'b0;
    bus.JumpAddr   = 32'h0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    do_reset();

    // Sequential fetch with one-cycle memory latency
    chk("first_req", {31'b0, bus.imem_req}, 32'h1);
    chk("first_addr", bus.imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("id_w0", bus.Instruction_id, w(32'h0));
    chk("pcid_0", bus.PC_id, 32'h0);
    chk("addr_4", bus.imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("id_w4", bus.Instruction_id, w(32'h4));
    chk("pcid_4", bus.PC_id, 32'h4);
    chk("addr_8", bus.imem_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("wait_cnt_3", bus.fetch_wait_cnt, 32'd3);
    chk("flush_cnt_0", bus.flush_cnt, 32'd0);
`endif

    // ID stalls for three cycles as the word at 8 returns
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
    chk("stall_pcid", bus.PC_id, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_pcid_3", bus.PC_id, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("unstall_pcid", bus.PC_id, 32'h8);
    chk("unstall_id", bus.Instruction_id, w(32'h8));
    chk("unstall_addr", bus.imem_addr, 32'hC);
    chk("unstall_req", {31'b0, bus.imem_req}, 32'h1);

    // Jump while the request to 0x10 is outstanding (response two cycles after issue)
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("addr_10", bus.imem_addr, 32'h10);
    fix_lat = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h100);
    chk("jump_nop", bus.Instruction_id, NOP);
`ifdef IF_PERF_CNT_EN
    chk("flush_cnt_1", bus.flush_cnt, 32'd1);
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("late_dropped", bus.Instruction_id, NOP);
    chk("jump_req", {31'b0, bus.imem_req}, 32'h1);
    chk("jump_addr", bus.imem_addr, 32'h100);
    fix_lat = 0;

    // Branch during a stall is ignored
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h200);
    chk("br_stall_addr", bus.imem_addr, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h200);
    chk("br_stall_addr2", bus.imem_addr, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("br_ignored_pcid", bus.PC_id, 32'h100);
    chk("br_ignored_addr", bus.imem_addr, 32'h104);

    // PC wraps past the top of the address space
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_target", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_req", {31'b0, bus.imem_req}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pcid", bus.PC_id, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Randomized traffic against the reference model, with a reset in the middle
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ja;
      if (i == 700) do_reset();
      ja = $urandom;
      if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) ja = 32'hFFFF_FFF8 + {29'b0, ja[2], 2'b00};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 15) == 0, ja);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction inserted into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IFWrite  input  1  ID hazard enable; 0 = freeze PC and IF/ID.
REQ-006 Branch  input  1  ID branch-taken.
REQ-007 Jump  input  1  ID JAL/JALR.
REQ-008 JumpAddr  input  32  redirect target from ID.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; always equals current PC.
REQ-011 imem_valid  input  1  response strobe, one cycle, for the outstanding request.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-013 Instruction_id  output  32  IF/ID instruction register.
REQ-014 PC_id  output  32  IF/ID PC register.

Function
REQ-015 Redirect = (Branch|Jump) & IFWrite; Branch/Jump ignored while IFWrite=0.
REQ-016 At most one outstanding request; imem_req and imem_addr held stable from assertion until the cycle imem_valid=1.
REQ-017 FSM states: REQ (request outstanding), HOLD (word captured, ID stalled), DROP (discarding stale response).
REQ-018 REQ, imem_valid=1, IFWrite=1, no redirect: IF/ID <= {imem_rdata, PC}; PC <= PC+4 (mod 2^32); stay REQ, imem_req stays 1 with new address next cycle.
REQ-019 REQ, imem_valid=1, IFWrite=0: word and PC into hold register; imem_req=0; go HOLD; PC and IF/ID unchanged.
REQ-020 HOLD, IFWrite=1, no redirect: IF/ID <= hold contents; PC <= PC+4; go REQ.
REQ-021 REQ, imem_valid=0, IFWrite=1, no redirect: IF/ID <= {NOP_INSTR, PC_id unchanged} (bubble).
REQ-022 Redirect in any state: PC <= JumpAddr; IF/ID <= {NOP_INSTR, PC_id unchanged}; hold register discarded.
REQ-023 Redirect in REQ with imem_valid=0: go DROP; imem_req=0 in DROP; on imem_valid=1 discard word, go REQ at JumpAddr.
REQ-024 Redirect in REQ with imem_valid=1, or in HOLD: response discarded; go REQ, next request at JumpAddr.
REQ-025 Redirect coincident with response in DROP: PC <= new JumpAddr, go REQ.
REQ-026 Fetch-to-Instruction_id latency: one cycle after imem_valid when IFWrite=1.
REQ-027 JumpAddr[1:0] taken as-is; no misalignment check.

Reset
REQ-028 During reset: PC=RESET_PC, Instruction_id=NOP_INSTR, PC_id=32'h0, state=REQ, hold register cleared, counters 0.
REQ-029 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
REQ-030 Reset mid-request: any later imem_valid for the aborted request is not excluded by the block; memory shares reset and drops it.

Configuration
REQ-031 Macro IF_PERF_CNT_EN: defined adds outputs fetch_wait_cnt[31:0] (cycles in REQ with imem_valid=0) and flush_cnt[31:0] (redirect cycles), both wrap at 2^32, reset to 0; undefined, ports and logic absent, behaviour otherwise identical.

Verification
REQ-032 Reset release, memory 1-cycle latency, IFWrite=1: imem_addr 0,4,8; Instruction_id equals returned words one cycle after each imem_valid; PC_id 0,4,8.
REQ-033 IFWrite=0 for 3 cycles when word at PC=8 returns: imem_req=0, IF/ID holds PC_id=4; after IFWrite=1, PC_id=8 next cycle, imem_addr=12.
REQ-034 Jump=1, JumpAddr=32'h100 while request to 0x10 outstanding (valid 2 cycles later): Instruction_id=NOP, late word dropped, next imem_addr=0x100.
REQ-035 Branch=1 with IFWrite=0: ignored; PC unchanged until stall clears.
REQ-036 PC=32'hFFFF_FFFC fetched: next imem_addr=32'h0000_0000.
REQ-037 IF_PERF_CNT_EN defined, 3 wait cycles and 1 jump: fetch_wait_cnt=3, flush_cnt=1; reset mid-run clears both to 0.
